// File: rtl/vfb_pkg.sv
// Shared types and widths for the video frame-buffer pixel packer.
package vfb_pkg;

   localparam int CNT_W  = 12;
   localparam int PIX_W  = 16;
   localparam int WORD_W = 32;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_WAIT_VS = 1'b0,
      ST_FRAME   = 1'b1
   } state_e;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

endpackage

// File: rtl/vfb_pixel_packer.sv
// Packs pairs of RGB565 pixels into 32-bit words for a frame buffer and
// checks line/frame geometry against the expected resolution.
module vfb_pixel_packer
   import vfb_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vs_n,
   input  logic              de,
   input  logic [PIX_W-1:0]  data,
   input  logic              wr_full,
   input  logic              err_clr,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_data,
   output logic              wr_sof,
   output logic              frame_done,
   output logic [CNT_W-1:0]  last_h_cnt,
   output logic [CNT_W-1:0]  last_v_cnt,
   output logic              err_line,
   output logic              err_frame,
   output logic              err_ovf
);

   localparam logic [CNT_W-1:0] H_RES_C = CNT_W'(H_RES);
   localparam logic [CNT_W-1:0] V_RES_C = CNT_W'(V_RES);

   // input stage and its one-cycle-delayed copy
   logic              vs_s1_q, de_s1_q, vs_prev_q, de_prev_q;
   logic [PIX_W-1:0]  data_s1_q;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
   logic [PIX_W-1:0]  half_q, half_d;
   logic              half_vld_q, half_vld_d;
   logic              wr_vld_q, wr_vld_d;
   logic [WORD_W-1:0] wr_data_q, wr_data_d;
   logic              sof_pend_q, sof_pend_d;
   logic              frame_done_q, frame_done_d;
   logic [CNT_W-1:0]  last_h_q, last_h_d;
   logic [CNT_W-1:0]  last_v_q, last_v_d;
   logic              err_line_q, err_line_d;
   logic              err_frame_q, err_frame_d;
   logic              err_ovf_q, err_ovf_d;

   logic              vs_fall, de_rise, de_fall, pix_vld, wr_take;
   logic              line_set, frame_set, ovf_set;
   logic [CNT_W-1:0]  line_total;

   // Register sync/valid/data once; keep the previous S1 sample for edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_s1_q   <= 1'b1;
         de_s1_q   <= 1'b0;
         data_s1_q <= {PIX_W{1'b0}};
         vs_prev_q <= 1'b1;
         de_prev_q <= 1'b0;
      end else begin
         vs_s1_q   <= vs_n;
         de_s1_q   <= de;
         data_s1_q <= data;
         vs_prev_q <= vs_s1_q;
         de_prev_q <= de_s1_q;
      end
   end

   // Edge strobes; pixels during vertical sync or before lock are ignored.
   always_comb begin
      vs_fall = vs_prev_q & ~vs_s1_q;
      de_rise = de_s1_q & ~de_prev_q;
      de_fall = ~de_s1_q & de_prev_q;
      pix_vld = (state_q == ST_FRAME) & de_s1_q & vs_s1_q;
      wr_take = wr_vld_q & ~wr_full;
   end

   // Next-state for FSM, packing, geometry counters and sticky errors.
   always_comb begin
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      line_cnt_d   = line_cnt_q;
      half_d       = half_q;
      half_vld_d   = half_vld_q;
      wr_vld_d     = 1'b0;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      last_h_d     = last_h_q;
      last_v_d     = last_v_q;
      line_set     = 1'b0;
      frame_set    = 1'b0;
      line_total   = line_cnt_q;
      case (state_q)
         ST_WAIT_VS: begin
            if (vs_fall) begin
               state_d    = ST_FRAME;
               line_cnt_d = CNT_ZERO;
               pix_cnt_d  = CNT_ZERO;
               half_vld_d = 1'b0;
            end else begin
               state_d = ST_WAIT_VS;
            end
         end
         ST_FRAME: begin
            state_d = ST_FRAME;
            // a new line restarts the count, counting its first pixel if present
            if (de_rise) begin
               pix_cnt_d = pix_vld ? CNT_ONE : CNT_ZERO;
            end else if (pix_vld) begin
               pix_cnt_d = sat_inc(pix_cnt_q);
            end else begin
               pix_cnt_d = pix_cnt_q;
            end
            if (pix_vld) begin
               if (half_vld_q && !de_rise) begin
                  wr_vld_d   = 1'b1;
                  wr_data_d  = {data_s1_q, half_q};
                  half_vld_d = 1'b0;
               end else begin
                  half_d     = data_s1_q;
                  half_vld_d = 1'b1;
               end
            end else if (de_fall && half_vld_q) begin
               wr_vld_d   = 1'b1;
               wr_data_d  = {{PIX_W{1'b0}}, half_q};
               half_vld_d = 1'b0;
            end else begin
               half_vld_d = half_vld_q;
            end
            // line completes first so a coincident frame edge sees it
            if (de_fall) begin
               last_h_d   = pix_cnt_q;
               line_total = sat_inc(line_cnt_q);
               line_set   = (pix_cnt_q != H_RES_C);
            end else begin
               line_total = line_cnt_q;
            end
            if (vs_fall) begin
               last_v_d     = line_total;
               frame_done_d = 1'b1;
               frame_set    = (line_total != V_RES_C);
               line_cnt_d   = CNT_ZERO;
               half_vld_d   = 1'b0;
               wr_vld_d     = 1'b0;
            end else begin
               line_cnt_d = line_total;
            end
         end
         default: begin
            state_d = ST_WAIT_VS;
         end
      endcase
      // a new frame re-arms start-of-frame; it survives dropped words
      if (vs_fall) begin
         sof_pend_d = 1'b1;
      end else if (wr_take) begin
         sof_pend_d = 1'b0;
      end else begin
         sof_pend_d = sof_pend_q;
      end
      ovf_set     = wr_vld_q & wr_full;
      err_line_d  = line_set  | (err_line_q  & ~err_clr);
      err_frame_d = frame_set | (err_frame_q & ~err_clr);
      err_ovf_d   = ovf_set   | (err_ovf_q   & ~err_clr);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WAIT_VS;
         pix_cnt_q    <= CNT_ZERO;
         line_cnt_q   <= CNT_ZERO;
         half_q       <= {PIX_W{1'b0}};
         half_vld_q   <= 1'b0;
         wr_vld_q     <= 1'b0;
         wr_data_q    <= {WORD_W{1'b0}};
         sof_pend_q   <= 1'b0;
         frame_done_q <= 1'b0;
         last_h_q     <= CNT_ZERO;
         last_v_q     <= CNT_ZERO;
         err_line_q   <= 1'b0;
         err_frame_q  <= 1'b0;
         err_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         line_cnt_q   <= line_cnt_d;
         half_q       <= half_d;
         half_vld_q   <= half_vld_d;
         wr_vld_q     <= wr_vld_d;
         wr_data_q    <= wr_data_d;
         sof_pend_q   <= sof_pend_d;
         frame_done_q <= frame_done_d;
         last_h_q     <= last_h_d;
         last_v_q     <= last_v_d;
         err_line_q   <= err_line_d;
         err_frame_q  <= err_frame_d;
         err_ovf_q    <= err_ovf_d;
      end
   end

   assign wr_en      = wr_take;
   assign wr_sof     = wr_take & sof_pend_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign last_h_cnt = last_h_q;
   assign last_v_cnt = last_v_q;
   assign err_line   = err_line_q;
   assign err_frame  = err_frame_q;
   assign err_ovf    = err_ovf_q;

endmodule
